sisc_core_ctl: RTL and testbench

// - Execute/control slice of the SISC processor: the ALU, the branch-target adder and the multicycle control FSM in one block.
// - Sits between the register file, status register, PC and instruction memory.
// - Decodes IR, sequences each instruction through fetch/decode/execute/writeback, and computes ALU results, condition codes and branch targets.

---
 rtl/sisc_core_ctl.sv | 173 +++++++++++++++++
 tb/tb_sisc_core_ctl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_core_ctl.sv
// SISC execute/control slice: instruction decode, multicycle control FSM,
// 32-bit ALU with {C,V,N,Z} condition codes, and the branch-target adder.
module sisc_core_ctl (
    input  logic        CLK,
    input  logic        RST_F,
    input  logic [31:0] IR,
    input  logic [31:0] RSA,
    input  logic [31:0] RSB,
    input  logic [3:0]  STAT,
    input  logic [15:0] PC_INC,
    output logic [31:0] ALU_RESULT,
    output logic [3:0]  CC,
    output logic        CC_EN,
    output logic        RF_WE,
    output logic        WB_SEL,
    output logic        RD_SEL,
    output logic        PC_SEL,
    output logic        PC_WRITE,
    output logic        PC_RST,
    output logic        BR_SEL,
    output logic [15:0] BR_ADDR,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_START0    = 3'd0,
        S_START1    = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_EXECUTE   = 3'd4,
        S_MEM       = 3'd5,
        S_WRITEBACK = 3'd6,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_ALU_R = 4'b0001;
    localparam logic [3:0] OP_ALU_I = 4'b0010;
    localparam logic [3:0] OP_HLT   = 4'b1111;

    state_t state_q, state_d;

    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] imm;
    logic        is_alu_r, is_alu_i, is_alu, is_br, is_hlt;
    logic        cond, br_taken, br_abs;
    logic        active;
    logic [7:0]  unused_ir_regs;

    assign opcode         = IR[31:28];
    assign mm             = IR[27:24];
    assign imm            = IR[15:0];
    assign unused_ir_regs = IR[23:16];

    assign is_alu_r = (opcode == OP_ALU_R);
    assign is_alu_i = (opcode == OP_ALU_I);
    assign is_alu   = is_alu_r | is_alu_i;
    assign is_hlt   = (opcode == OP_HLT);
    // Branch opcodes are 01xx: bit1 inverts the condition, bit0 selects relative.
    assign is_br    = (opcode[3:2] == 2'b01);
    assign cond     = |(STAT & mm);
    assign br_taken = is_br & (cond ^ opcode[1]);
    assign br_abs   = ~opcode[0];

    assign active    = (state_q != S_START0) && (state_q != S_START1) && (state_q != S_HALT);
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_START0:    state_d = S_START1;
            S_START1:    state_d = S_FETCH;
            S_FETCH:     state_d = S_DECODE;
            S_DECODE:    state_d = is_hlt ? S_HALT : S_EXECUTE;
            S_EXECUTE:   state_d = S_MEM;
            S_MEM:       state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_START0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_F) begin
        if (!RST_F) begin
            state_q <= S_START0;
        end else begin
            state_q <= state_d;
        end
    end

    // ALU datapath; ALU_I takes a zero-extended immediate as operand B.
    logic [31:0] op_b;
    logic [32:0] sum;
    logic [32:0] diff;
    logic [31:0] alu_res;
    logic        flag_c, flag_v;

    always_comb begin
        op_b    = is_alu_i ? {16'h0000, imm} : RSB;
        sum     = {1'b0, RSA} + {1'b0, op_b};
        diff    = {1'b0, RSA} - {1'b0, op_b};
        alu_res = RSA;
        flag_c  = 1'b0;
        flag_v  = 1'b0;
        case (mm)
            4'b0001: begin
                alu_res = sum[31:0];
                flag_c  = sum[32];
                flag_v  = (RSA[31] == op_b[31]) && (sum[31] != RSA[31]);
            end
            4'b0010: begin
                alu_res = diff[31:0];
                flag_c  = diff[32];
                flag_v  = (RSA[31] != op_b[31]) && (diff[31] != RSA[31]);
            end
            4'b0011: alu_res = RSA | op_b;
            4'b0100: alu_res = RSA & op_b;
            4'b0101: alu_res = RSA ^ op_b;
            4'b0110: alu_res = ~RSA;
            4'b0111: alu_res = RSA << op_b[4:0];
            4'b1000: alu_res = RSA >> op_b[4:0];
            default: alu_res = RSA;
        endcase
    end

    always_comb begin
        ALU_RESULT = 32'h0;
        CC         = 4'h0;
        BR_ADDR    = 16'h0;
        if (active) begin
            ALU_RESULT = alu_res;
            CC         = {flag_c, flag_v, alu_res[31], (alu_res == 32'h0)};
            BR_ADDR    = BR_SEL ? imm : (PC_INC + imm);
        end
    end

    always_comb begin
        CC_EN    = 1'b0;
        RF_WE    = 1'b0;
        WB_SEL   = 1'b0;
        RD_SEL   = 1'b0;
        PC_SEL   = 1'b0;
        PC_WRITE = 1'b0;
        PC_RST   = 1'b0;
        BR_SEL   = 1'b0;
        case (state_q)
            S_START0: PC_RST = 1'b1;
            S_FETCH:  PC_WRITE = 1'b1;
            S_DECODE: begin
                RD_SEL = is_alu_i;
                if (is_br) begin
                    BR_SEL = br_abs;
                end
                if (br_taken) begin
                    PC_SEL   = 1'b1;
                    PC_WRITE = 1'b1;
                end
            end
            S_EXECUTE: begin
                CC_EN  = is_alu;
                RD_SEL = is_alu_i;
            end
            S_MEM: RD_SEL = is_alu_i;
            S_WRITEBACK: begin
                RF_WE  = is_alu;
                WB_SEL = is_alu;
                RD_SEL = is_alu_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sisc_core_ctl.sv
// Self-checking bench for sisc_core_ctl: ALU vector table, random ALU ops
// against a reference model, branch/NOP/HLT sequences and reset abort.
module tb_sisc_core_ctl;

    localparam logic [2:0] S_START0 = 3'd0;
    localparam logic [2:0] S_START1 = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_DECODE = 3'd3;
    localparam logic [2:0] S_EXEC   = 3'd4;
    localparam logic [2:0] S_MEM    = 3'd5;
    localparam logic [2:0] S_WB     = 3'd6;
    localparam logic [2:0] S_HALT   = 3'd7;

    logic        CLK, RST_F;
    logic [31:0] IR, RSA, RSB;
    logic [3:0]  STAT;
    logic [15:0] PC_INC;
    logic [31:0] ALU_RESULT;
    logic [3:0]  CC;
    logic        CC_EN, RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL;
    logic [15:0] BR_ADDR;
    logic [2:0]  dbg_state;
    logic [7:0]  ctl;

    int n_checks = 0;
    int n_fail   = 0;
    logic [35:0] exp_q[$];

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [31:0] a;
        logic [31:0] b;
        logic [15:0] imm;
        logic [31:0] res;
        logic [3:0]  cc;
    } vec_t;
    vec_t vecs[14];

    sisc_core_ctl dut (
        .CLK(CLK), .RST_F(RST_F), .IR(IR), .RSA(RSA), .RSB(RSB), .STAT(STAT),
        .PC_INC(PC_INC), .ALU_RESULT(ALU_RESULT), .CC(CC), .CC_EN(CC_EN),
        .RF_WE(RF_WE), .WB_SEL(WB_SEL), .RD_SEL(RD_SEL), .PC_SEL(PC_SEL),
        .PC_WRITE(PC_WRITE), .PC_RST(PC_RST), .BR_SEL(BR_SEL), .BR_ADDR(BR_ADDR),
        .dbg_state(dbg_state)
    );

    assign ctl = {CC_EN, RF_WE, WB_SEL, RD_SEL, PC_SEL, PC_WRITE, PC_RST, BR_SEL};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int i;
        for (i = 0; i < 12; i++) begin
            if (dbg_state == s) break;
            step();
        end
        chk($sformatf("%s_wait_state", tag), 32'(dbg_state), 32'(s));
    endtask

    // Reference ALU: 64-bit arithmetic, overflow judged by signed range.
    function automatic void alu_model(input logic [3:0] mm, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] res,
                                      output logic [3:0] cc);
        longint     ss;
        logic [63:0] wide;
        logic       c, v;
        c = 1'b0;
        v = 1'b0;
        case (mm)
            4'd1: begin
                wide = {32'h0, a} + {32'h0, b};
                res  = wide[31:0];
                c    = (wide > 64'h0000_0000_FFFF_FFFF);
                ss   = longint'($signed(a)) + longint'($signed(b));
                v    = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd2: begin
                res = a - b;
                c   = (a < b);
                ss  = longint'($signed(a)) - longint'($signed(b));
                v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd3: res = a | b;
            4'd4: res = a & b;
            4'd5: res = a ^ b;
            4'd6: res = ~a;
            4'd7: res = a << b[4:0];
            4'd8: res = a >> b[4:0];
            default: res = a;
        endcase
        cc = {c, v, res[31], (res == 32'h0)};
    endfunction

    task automatic run_alu(input logic [3:0] op, input logic [3:0] mm, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] imm,
                           input logic [31:0] exp_res, input logic [3:0] exp_cc, input string tag);
        logic [35:0] got;
        logic        exp_rd;
        exp_rd = (op == 4'b0010);
        wait_state(S_FETCH, tag);
        IR  = {op, mm, 4'h1, 4'h2, imm};
        RSA = a;
        RSB = b;
        exp_q.push_back({exp_cc, exp_res});
        #1;
        chk($sformatf("%s_fetch_ctl", tag), 32'(ctl), 32'h04);
        step();
        chk($sformatf("%s_decode_wr", tag), 32'({PC_WRITE, RF_WE, CC_EN}), 32'h0);
        step();
        chk($sformatf("%s_exec_state", tag), 32'(dbg_state), 32'(S_EXEC));
        chk($sformatf("%s_exec_cc_en", tag), 32'({CC_EN, RF_WE, PC_WRITE}), 32'b100);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_scoreboard actual=empty required=entry", tag);
            got = '0;
        end else begin
            got = exp_q.pop_front();
        end
        chk($sformatf("%s_result", tag), ALU_RESULT, got[31:0]);
        chk($sformatf("%s_cc", tag), 32'(CC), 32'(got[35:32]));
        step();
        chk($sformatf("%s_mem_wr", tag), 32'({CC_EN, RF_WE, PC_WRITE}), 32'h0);
        step();
        chk($sformatf("%s_wb_ctl", tag), 32'({RF_WE, WB_SEL, RD_SEL, CC_EN, PC_WRITE}),
            32'({1'b1, 1'b1, exp_rd, 1'b0, 1'b0}));
        chk($sformatf("%s_wb_result", tag), ALU_RESULT, got[31:0]);
    endtask

    task automatic run_br(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                          input logic [15:0] pc_inc, input logic [15:0] imm, input logic taken,
                          input logic exp_brsel, input logic [15:0] exp_addr, input string tag);
        wait_state(S_FETCH, tag);
        IR     = {op, mm, 8'h00, imm};
        STAT   = stat;
        PC_INC = pc_inc;
        step();
        chk($sformatf("%s_pc_wr_sel", tag), 32'({PC_WRITE, PC_SEL}), 32'({taken, taken}));
        if (taken) begin
            chk($sformatf("%s_br_sel", tag), 32'(BR_SEL), 32'(exp_brsel));
            chk($sformatf("%s_br_addr", tag), 32'(BR_ADDR), 32'(exp_addr));
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("%s_idle%0d", tag, i), 32'({RF_WE, CC_EN, PC_WRITE, WB_SEL}), 32'h0);
        end
        STAT = 4'h0;
    endtask

    initial begin
        vecs[0]  = '{4'h1, 4'h1, 32'h7FFFFFFF, 32'h00000001, 16'h3000, 32'h80000000, 4'b0110};
        vecs[1]  = '{4'h2, 4'h2, 32'h00000005, 32'hDEADBEEF, 16'h0005, 32'h00000000, 4'b0001};
        vecs[2]  = '{4'h2, 4'h2, 32'h00000000, 32'hDEADBEEF, 16'h0001, 32'hFFFFFFFF, 4'b1010};
        vecs[3]  = '{4'h1, 4'h1, 32'hFFFFFFFF, 32'h00000001, 16'h3000, 32'h00000000, 4'b1001};
        vecs[4]  = '{4'h1, 4'h2, 32'h80000000, 32'h00000001, 16'h3000, 32'h7FFFFFFF, 4'b0100};
        vecs[5]  = '{4'h1, 4'h3, 32'hF0F00000, 32'h0000000F, 16'h3000, 32'hF0F0000F, 4'b0010};
        vecs[6]  = '{4'h1, 4'h4, 32'hFF00FF00, 32'h0F0F0F0F, 16'h3000, 32'h0F000F00, 4'b0000};
        vecs[7]  = '{4'h1, 4'h5, 32'hAAAAAAAA, 32'hAAAAAAAA, 16'h3000, 32'h00000000, 4'b0001};
        vecs[8]  = '{4'h1, 4'h6, 32'h00000000, 32'h12345678, 16'h3000, 32'hFFFFFFFF, 4'b0010};
        vecs[9]  = '{4'h2, 4'h7, 32'h00000001, 32'hDEADBEEF, 16'h001F, 32'h80000000, 4'b0010};
        vecs[10] = '{4'h1, 4'h8, 32'h80000000, 32'h00000024, 16'h3000, 32'h08000000, 4'b0000};
        vecs[11] = '{4'h1, 4'h9, 32'h12345678, 32'hFFFFFFFF, 16'h3000, 32'h12345678, 4'b0000};
        vecs[12] = '{4'h2, 4'h1, 32'h00000001, 32'hFFFFFFFF, 16'hFFFF, 32'h00010000, 4'b0000};
        vecs[13] = '{4'h1, 4'h0, 32'h00000000, 32'h55555555, 16'h3000, 32'h00000000, 4'b0001};

        RST_F = 1'b1; IR = 32'h0; RSA = 32'h0; RSB = 32'h0; STAT = 4'h0; PC_INC = 16'h0;
        #1 RST_F = 1'b0;
        #2;
        chk("reset_state", 32'(dbg_state), 32'(S_START0));
        chk("reset_ctl", 32'(ctl), 32'h02);
        chk("reset_datapath", 32'({CC, BR_ADDR}), 32'h0);
        step();
        step();
        RST_F = 1'b1;
        step();
        chk("start1_state", 32'(dbg_state), 32'(S_START1));
        chk("start1_ctl", 32'(ctl), 32'h00);
        step();
        chk("first_fetch_ctl", 32'(ctl), 32'h04);

        foreach (vecs[i])
            run_alu(vecs[i].op, vecs[i].mm, vecs[i].a, vecs[i].b, vecs[i].imm,
                    vecs[i].res, vecs[i].cc, $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            logic [3:0]  op, mm;
            logic [31:0] a, b, beff, r;
            logic [15:0] imm;
            logic [3:0]  c;
            op   = 4'($urandom_range(1, 2));
            mm   = 4'($urandom_range(0, 15));
            a    = $urandom;
            b    = $urandom;
            imm  = 16'($urandom_range(0, 65535));
            beff = (op == 4'h2) ? {16'h0, imm} : b;
            alu_model(mm, a, beff, r, c);
            run_alu(op, mm, a, b, imm, r, c, $sformatf("rnd%0d", i));
        end

        run_br(4'b0100, 4'b0001, 4'b0001, 16'h0005, 16'h0040, 1'b1, 1'b1, 16'h0040, "bra_taken");
        run_br(4'b0100, 4'b0001, 4'b0000, 16'h0005, 16'h0040, 1'b0, 1'b1, 16'h0040, "bra_not");
        run_br(4'b0111, 4'b0001, 4'b0000, 16'h0010, 16'hFFFE, 1'b1, 1'b0, 16'h000E, "bnr_taken");
        run_br(4'b0110, 4'b0110, 4'b0100, 16'h0010, 16'h0020, 1'b0, 1'b1, 16'h0020, "bne_not");
        run_br(4'b0101, 4'b1000, 4'b1000, 16'h1000, 16'h0010, 1'b1, 1'b0, 16'h1010, "brr_taken");
        run_br(4'b0000, 4'b0001, 4'b1111, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "nop");
        run_br(4'b1010, 4'b0001, 4'b1111, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, "undef_op");

        // Reset asserted mid-WRITEBACK must drop RF_WE without waiting for a clock.
        wait_state(S_FETCH, "rst_mid");
        IR = {4'h1, 4'h1, 4'h1, 4'h2, 16'h3000};
        RSA = 32'h1;
        RSB = 32'h1;
        step(); step(); step(); step();
        chk("rst_mid_wb_we", 32'(RF_WE), 32'h1);
        RST_F = 1'b0;
        #1;
        chk("rst_mid_we_drop", 32'(RF_WE), 32'h0);
        chk("rst_mid_state", 32'(dbg_state), 32'(S_START0));
        step();
        RST_F = 1'b1;
        #1;
        chk("rst_rel_start0", 32'({dbg_state, ctl}), 32'({S_START0, 8'h02}));
        step();
        chk("rst_rel_start1", 32'({dbg_state, ctl}), 32'({S_START1, 8'h00}));
        step();
        chk("rst_rel_fetch", 32'({dbg_state, ctl}), 32'({S_FETCH, 8'h04}));

        wait_state(S_FETCH, "hlt");
        IR = 32'hF000_0000;
        step();
        step();
        chk("hlt_state", 32'(dbg_state), 32'(S_HALT));
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("hlt_idle%0d", i), 32'({dbg_state, ctl}), 32'({S_HALT, 8'h00}));
            step();
        end
        RST_F = 1'b0;
        #1;
        chk("hlt_reset_state", 32'({dbg_state, ctl}), 32'({S_START0, 8'h02}));
        step();
        RST_F = 1'b1;
        IR = 32'h0;
        step();
        step();
        chk("hlt_recover_fetch", 32'({dbg_state, ctl}), 32'({S_FETCH, 8'h04}));
        run_alu(4'h1, 4'h1, 32'h00000002, 32'h00000003, 16'h3000, 32'h00000005, 4'b0000, "post_hlt");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
